// File: rtl/vec_unit_ctrl.sv
// vec_unit_ctrl: command sequencer for the vector unit.
// Buffers vector-op commands in a FIFO. For each command it issues one RF read,
// waits RD_LAT cycles, then writes the vector-unit result back and signals done.
// No vector data passes through this block; it only drives control and addresses.
// Optional build macro: VEC_CTRL_PERF_EN adds the perf_cmds and perf_busy_cycles counters.
module vec_unit_ctrl #(
  parameter int REG_AW    = 3,
  parameter int CMD_DEPTH = 4,
  parameter int RD_LAT    = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [2:0]                     cmd_op,
  input  logic [REG_AW-1:0]              cmd_dst,
  input  logic [REG_AW-1:0]              cmd_src1,
  input  logic [REG_AW-1:0]              cmd_src2,
  input  logic                           halt,
  output logic                           rf_rd_en,
  output logic [REG_AW-1:0]              rf_rd_addr1,
  output logic [REG_AW-1:0]              rf_rd_addr2,
  output logic [2:0]                     vu_op,
  output logic                           rf_wr_en,
  output logic [REG_AW-1:0]              rf_wr_addr,
  output logic                           busy,
  output logic                           done,
  output logic [REG_AW-1:0]              done_dst,
  output logic [$clog2(CMD_DEPTH):0]     fifo_count
`ifdef VEC_CTRL_PERF_EN
  ,
  output logic [31:0]                    perf_cmds,
  output logic [31:0]                    perf_busy_cycles
`endif
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int EW = 3 + 3 * REG_AW;

  typedef enum logic [1:0] {IDLE, READ, EXEC} state_t;

  state_t              state, state_next;
  logic [EW-1:0]       fifo_mem [CMD_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW:0]         count;
  logic                push, pop, full;
  logic [2:0]          wait_cnt;
  logic                wait_last;
  logic [2:0]          cur_op;
  logic [REG_AW-1:0]   cur_dst, cur_src1, cur_src2;

  // cmd_ready looks only at occupancy, so a full FIFO refuses a push even if it pops that cycle
  assign full      = (count == (PW+1)'(CMD_DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign wait_last = (wait_cnt == 3'(RD_LAT - 1));

  assign fifo_count  = count;
  assign busy        = (state != IDLE) || (count != '0);
  assign rf_rd_addr1 = cur_src1;
  assign rf_rd_addr2 = cur_src2;
  assign rf_wr_addr  = cur_dst;

  // FIFO storage; contents are don't-care while the slot is empty, so no reset needed
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_op, cmd_dst, cmd_src1, cmd_src2};
  end

  // FIFO pointers and occupancy; pointers wrap naturally because depth is a power of two
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and strobes: halt only matters in IDLE, a popped command always finishes
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    rf_rd_en   = 1'b0;
    rf_wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && !halt) begin
          pop        = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        rf_rd_en = (wait_cnt == 3'd0);
        if (wait_last) state_next = EXEC;
      end
      EXEC: begin
        rf_wr_en   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Current command, read-latency counter, op select and completion pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_op   <= '0;
      cur_dst  <= '0;
      cur_src1 <= '0;
      cur_src2 <= '0;
      wait_cnt <= '0;
      vu_op    <= '0;
      done     <= 1'b0;
      done_dst <= '0;
    end else begin
      if (pop) begin
        {cur_op, cur_dst, cur_src1, cur_src2} <= fifo_mem[rd_ptr];
        wait_cnt <= '0;
      end else if (state == READ) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if ((state == READ) && wait_last) vu_op <= cur_op;
      done <= (state == EXEC);
      if (state == EXEC) done_dst <= cur_dst;
    end
  end

`ifdef VEC_CTRL_PERF_EN
  // Performance counters: completed commands and non-idle cycles, both wrapping at 2**32
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_cmds        <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (done)           perf_cmds        <= perf_cmds + 32'd1;
      if (state != IDLE)  perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_unit_ctrl.sv
// tb_vec_unit_ctrl: directed self-checking bench for vec_unit_ctrl.
// Instance d1 uses RD_LAT=1, instance d3 uses RD_LAT=3 for the latency/alias case.
// Optional build macro: VEC_CTRL_PERF_EN enables the performance-counter checks.
module tb_vec_unit_ctrl;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic       c_valid, c_halt;
  logic [2:0] c_op, c_dst, c_src1, c_src2;
  logic       d1_ready, d1_rd_en, d1_wr_en, d1_busy, d1_done;
  logic [2:0] d1_addr1, d1_addr2, d1_vu_op, d1_wr_addr, d1_done_dst;
  logic [2:0] d1_count;

  logic       e_valid, e_halt;
  logic [2:0] e_op, e_dst, e_src1, e_src2;
  logic       d3_ready, d3_rd_en, d3_wr_en, d3_busy, d3_done;
  logic [2:0] d3_addr1, d3_addr2, d3_vu_op, d3_wr_addr, d3_done_dst;
  logic [2:0] d3_count;

`ifdef VEC_CTRL_PERF_EN
  logic [31:0] d1_perf_cmds, d1_perf_busy, d3_perf_cmds, d3_perf_busy;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  vec_unit_ctrl #(.REG_AW(3), .CMD_DEPTH(4), .RD_LAT(1)) d1 (
    .clock(clock), .reset_n(reset_n), .cmd_valid(c_valid), .cmd_ready(d1_ready),
    .cmd_op(c_op), .cmd_dst(c_dst), .cmd_src1(c_src1), .cmd_src2(c_src2), .halt(c_halt),
    .rf_rd_en(d1_rd_en), .rf_rd_addr1(d1_addr1), .rf_rd_addr2(d1_addr2), .vu_op(d1_vu_op),
    .rf_wr_en(d1_wr_en), .rf_wr_addr(d1_wr_addr), .busy(d1_busy), .done(d1_done),
    .done_dst(d1_done_dst), .fifo_count(d1_count)
`ifdef VEC_CTRL_PERF_EN
    , .perf_cmds(d1_perf_cmds), .perf_busy_cycles(d1_perf_busy)
`endif
  );

  vec_unit_ctrl #(.REG_AW(3), .CMD_DEPTH(4), .RD_LAT(3)) d3 (
    .clock(clock), .reset_n(reset_n), .cmd_valid(e_valid), .cmd_ready(d3_ready),
    .cmd_op(e_op), .cmd_dst(e_dst), .cmd_src1(e_src1), .cmd_src2(e_src2), .halt(e_halt),
    .rf_rd_en(d3_rd_en), .rf_rd_addr1(d3_addr1), .rf_rd_addr2(d3_addr2), .vu_op(d3_vu_op),
    .rf_wr_en(d3_wr_en), .rf_wr_addr(d3_wr_addr), .busy(d3_busy), .done(d3_done),
    .done_dst(d3_done_dst), .fifo_count(d3_count)
`ifdef VEC_CTRL_PERF_EN
    , .perf_cmds(d3_perf_cmds), .perf_busy_cycles(d3_perf_busy)
`endif
  );

  // Advance to just after the next rising edge, where inputs are driven and outputs sampled
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic v, input logic [2:0] op, dst, s1, s2);
    c_valid = v; c_op = op; c_dst = dst; c_src1 = s1; c_src2 = s2;
  endtask

  initial begin
    int n_done;
    int t_done [4];
    logic [2:0] dst_done [4];
    int t_rd, t_wr;
    logic addr_ok;

    drive1(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    c_halt = 1'b0;
    e_valid = 1'b0; e_op = '0; e_dst = '0; e_src1 = '0; e_src2 = '0; e_halt = 1'b0;

    // Test 1: reset state
    tick(); tick();
    check("rst_ready", d1_ready, 1);
    check("rst_busy", d1_busy, 0);
    check("rst_rd_en", d1_rd_en, 0);
    check("rst_wr_en", d1_wr_en, 0);
    check("rst_done", d1_done, 0);
    check("rst_count", d1_count, 0);
    check("rst_vu_op", d1_vu_op, 0);
    reset_n = 1'b1;
    tick();

    // Test 2: single command timing, cycle 0 is the push cycle
    drive1(1'b1, 3'd3, 3'd5, 3'd2, 3'd7);
    tick();
    drive1(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    check("c1_count", d1_count, 1);
    check("c1_rd_en", d1_rd_en, 0);
    check("c1_busy", d1_busy, 1);
    tick();
    check("c2_rd_en", d1_rd_en, 1);
    check("c2_addr1", d1_addr1, 2);
    check("c2_addr2", d1_addr2, 7);
    check("c2_count", d1_count, 0);
    tick();
    check("c3_wr_en", d1_wr_en, 1);
    check("c3_wr_addr", d1_wr_addr, 5);
    check("c3_vu_op", d1_vu_op, 3);
    check("c3_rd_en", d1_rd_en, 0);
    tick();
    check("c4_done", d1_done, 1);
    check("c4_done_dst", d1_done_dst, 5);
    check("c4_wr_en", d1_wr_en, 0);
    tick();
    check("c5_done", d1_done, 0);
    check("c5_busy", d1_busy, 0);
    check("c5_vu_op_hold", d1_vu_op, 3);

    // Test 3: fill under halt, refused fifth push, then drain in order
    c_halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive1(1'b1, 3'(i + 1), 3'(i + 1), 3'd0, 3'd0);
      tick();
    end
    check("fill_count", d1_count, 4);
    check("fill_ready", d1_ready, 0);
    drive1(1'b1, 3'd6, 3'd6, 3'd0, 3'd0);
    tick();
    drive1(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    check("fill_refused", d1_count, 4);
    check("fill_halt_rd", d1_rd_en, 0);
    c_halt = 1'b0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (d1_done) begin
        if (n_done < 4) begin
          t_done[n_done] = c;
          dst_done[n_done] = d1_done_dst;
        end
        n_done++;
      end
    end
    check("drain_n", n_done, 4);
    for (int i = 0; i < 4; i++) check($sformatf("drain_dst%0d", i), dst_done[i], i + 1);
    for (int i = 1; i < 4; i++) check($sformatf("drain_gap%0d", i), t_done[i] - t_done[i-1], 3);
    check("drain_busy", d1_busy, 0);

    // Test 4: reset asserted while in READ with a second command queued
    drive1(1'b1, 3'd1, 3'd6, 3'd1, 3'd2);
    tick();
    drive1(1'b1, 3'd2, 3'd7, 3'd3, 3'd4);
    tick();
    drive1(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    check("mid_rd_en", d1_rd_en, 1);
    check("mid_count", d1_count, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_count", d1_count, 0);
    check("mid_rst_wr_en", d1_wr_en, 0);
    check("mid_rst_busy", d1_busy, 0);
    tick();
    reset_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (d1_done || d1_wr_en || d1_rd_en) n_done++;
    end
    check("mid_no_activity", n_done, 0);

    // Test 5: aliased registers with RD_LAT=3 on instance d3
    e_valid = 1'b1; e_op = 3'd0; e_dst = 3'd1; e_src1 = 3'd1; e_src2 = 3'd1;
    t_rd = -1; t_wr = -1; addr_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      e_valid = 1'b0;
      if (d3_rd_en && t_rd < 0) t_rd = c + 1;
      if ((t_rd >= 0) && (t_wr < 0) && ((d3_addr1 !== 3'd1) || (d3_addr2 !== 3'd1))) addr_ok = 1'b0;
      if (d3_wr_en && t_wr < 0) begin
        t_wr = c + 1;
        check("lat_wr_addr", d3_wr_addr, 1);
        check("lat_vu_op", d3_vu_op, 0);
      end
    end
    check("lat_rd_cycle", t_rd, 2);
    check("lat_wr_minus_rd", t_wr - t_rd, 3);
    check("lat_addr_stable", addr_ok, 1);
    check("lat_idle", d3_busy, 0);

    // Test 6: three back-to-back commands on d1
`ifdef VEC_CTRL_PERF_EN
    check("perf_cmds_init", d1_perf_cmds, 0);
    check("perf_busy_init", d1_perf_busy, 0);
`endif
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      drive1(1'b1, 3'(i + 4), 3'(i), 3'd5, 3'd6);
      tick();
      if (d1_done) n_done++;
    end
    drive1(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    for (int c = 0; c < 30; c++) begin
      tick();
      if (d1_done) n_done++;
    end
    check("b2b_done_n", n_done, 3);
    check("b2b_idle", d1_busy, 0);
`ifdef VEC_CTRL_PERF_EN
    check("perf_cmds", d1_perf_cmds, 3);
    check("perf_busy_cycles", d1_perf_busy, 6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
